// File: rtl/maze_memory_ctrl.sv
// Maze bit-map store: working grid restored from a fixed image, registered reads,
// synchronous cell writes, and off-grid probes that read back as walls.
module maze_memory_ctrl #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int XW     = 4,
    parameter int YW     = 4,
    // Maze image, row 0 in the most significant WIDTH bits, each row MSB = column 0
    parameter logic [HEIGHT*WIDTH-1:0] IMAGE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic          d_in,
    input  logic          rd,
    input  logic          wr,
    input  logic          init_maze,
    output logic          d_out,
    output logic          valid,
    output logic          oob,
    output logic          busy,
    output logic          init_done,
    output logic          dbg_state
);

    localparam logic S_INIT = 1'b0;
    localparam logic S_IDLE = 1'b1;

    logic             r_state;
    logic [XW-1:0]    r_row_cnt;
    logic             r_d_out;
    logic             r_valid;
    logic             r_oob;
    logic             r_busy;
    logic             r_init_done;
    logic [WIDTH-1:0] r_grid [HEIGHT];

    logic [WIDTH-1:0] w_image [HEIGHT];
    logic             w_in_range;
    logic [YW-1:0]    w_bit;
    logic             w_idle_cmd;

    for (genvar g = 0; g < HEIGHT; g++) begin : g_image
        assign w_image[g] = IMAGE[(HEIGHT-1-g)*WIDTH +: WIDTH];
    end

    assign w_in_range = (int'(x) < HEIGHT) && (int'(y) < WIDTH);
    // Column 0 is the row word's MSB
    assign w_bit      = YW'(WIDTH - 1) - y;
    assign w_idle_cmd = (r_state == S_IDLE) && !init_maze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_row_cnt   <= '0;
            r_d_out     <= 1'b0;
            r_valid     <= 1'b0;
            r_oob       <= 1'b0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_oob       <= 1'b0;
            r_init_done <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (r_row_cnt == XW'(HEIGHT - 1)) begin
                        r_state     <= S_IDLE;
                        r_row_cnt   <= '0;
                        r_busy      <= 1'b0;
                        r_init_done <= 1'b1;
                    end else begin
                        r_row_cnt <= r_row_cnt + 1'b1;
                    end
                end
                default: begin
                    if (init_maze) begin
                        r_state   <= S_INIT;
                        r_row_cnt <= '0;
                        r_busy    <= 1'b1;
                    end else begin
                        if (rd) begin
                            r_valid <= 1'b1;
                            if (w_in_range) begin
                                r_d_out <= r_grid[x][w_bit];
                            end else begin
                                r_d_out <= 1'b1;
                                r_oob   <= 1'b1;
                            end
                        end
                        if (wr && !w_in_range) begin
                            r_oob <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Grid has no reset; the INIT pass rewrites every row after reset releases
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_grid[r_row_cnt] <= w_image[r_row_cnt];
        end else if (w_idle_cmd && wr && w_in_range) begin
            r_grid[x][w_bit] <= d_in;
        end
    end

    assign d_out     = r_d_out;
    assign valid     = r_valid;
    assign oob       = r_oob;
    assign busy      = r_busy;
    assign init_done = r_init_done;
    assign dbg_state = r_state;

endmodule
